// File: rtl/de_issue_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// de_issue_scoreboard_pkg
// Shared constants and types for the decode-stage issue controller:
//   - scoreboard geometry (REGWORDS, REGNOBITS, CNTBITS)
//   - control-resolve watchdog limit (CTRL_TIMEOUT)
//   - resolve FSM state encoding (IDLE=0, CTRL_WAIT=1, FLUSH=2)
// -----------------------------------------------------------------------------
package de_issue_scoreboard_pkg;

    localparam int REGWORDS     = 16;
    localparam int REGNOBITS    = 4;
    localparam int CNTBITS      = 2;
    localparam int CTRL_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CTRL_WAIT = 2'd1,
        FLUSH     = 2'd2
    } state_e;

endpackage

// File: rtl/de_issue_scoreboard_if.sv
// -----------------------------------------------------------------------------
// de_issue_scoreboard_if
// Bundles the decode/AGEX/WB inputs and the issue/stall/flush/status outputs of
// de_issue_scoreboard.
//   master : the pipeline side (drives DE/AGEX/WB info, observes issue control)
//   slave  : the issue controller
// All outputs are level signals sampled by the pipeline at the next posedge;
// there is no valid/ready handshake here, de_valid simply qualifies the DE
// fields and issue says the DE instruction is accepted at the coming edge.
// dbg_state exposes the resolve FSM state for observation.
// -----------------------------------------------------------------------------
interface de_issue_scoreboard_if;
    import de_issue_scoreboard_pkg::*;

    logic                 de_valid;
    logic                 de_read_rs;
    logic                 de_read_rt;
    logic [REGNOBITS-1:0] de_rs;
    logic [REGNOBITS-1:0] de_rt;
    logic                 de_wr_reg;
    logic [REGNOBITS-1:0] de_wregno;
    logic                 de_is_load;
    logic                 de_is_ctrl;
    logic                 agex_br_resolved;
    logic                 agex_br_mispred;
    logic                 wb_wr_reg;
    logic [REGNOBITS-1:0] wb_wregno;

    logic                 issue;
    logic                 dep_stall;
    logic                 ctrl_stall;
    logic                 flush;
    logic [REGWORDS-1:0]  busy_mask;
    logic                 err_overflow;
    logic                 err_underflow;
    logic                 err_timeout;
    state_e               dbg_state;

    modport master (
        output de_valid, de_read_rs, de_read_rt, de_rs, de_rt, de_wr_reg,
               de_wregno, de_is_load, de_is_ctrl, agex_br_resolved,
               agex_br_mispred, wb_wr_reg, wb_wregno,
        input  issue, dep_stall, ctrl_stall, flush, busy_mask,
               err_overflow, err_underflow, err_timeout, dbg_state
    );

    modport slave (
        input  de_valid, de_read_rs, de_read_rt, de_rs, de_rt, de_wr_reg,
               de_wregno, de_is_load, de_is_ctrl, agex_br_resolved,
               agex_br_mispred, wb_wr_reg, wb_wregno,
        output issue, dep_stall, ctrl_stall, flush, busy_mask,
               err_overflow, err_underflow, err_timeout, dbg_state
    );

endinterface

// File: rtl/de_issue_scoreboard_sb_counter.sv
// -----------------------------------------------------------------------------
// sb_counter
// One saturating up/down pending-writer counter of the register scoreboard.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_inc          : a writer of this register issues
//   i_dec          : WB retires a write to this register
//   o_cnt          : current pending-writer count
//   o_ovf          : strobe, increment requested while at max (count held)
//   o_unf          : strobe, decrement requested while at zero (count held)
// Simultaneous inc and dec cancel and never raise a strobe.
// -----------------------------------------------------------------------------
module sb_counter #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_ovf,
    output logic         o_unf
);

    localparam logic [W-1:0] MAXV = '1;

    logic [W-1:0] r_cnt;
    logic         w_up;
    logic         w_dn;

    always_comb begin
        w_up  = i_inc & ~i_dec;
        w_dn  = i_dec & ~i_inc;
        o_ovf = w_up & (r_cnt == MAXV);
        o_unf = w_dn & (r_cnt == '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_up && !o_ovf) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (w_dn && !o_unf) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/de_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// de_issue_scoreboard
// Decode-stage issue controller: per-register pending-writer scoreboard,
// one-bubble load-use hazard detection, and a resolve FSM that holds fetch
// while a branch/JAL is in flight and pulses flush on a mispredict.
//   i_clk   : clock, all state on posedge
//   i_rst_n : asynchronous active-low reset
//   io_sb   : de_issue_scoreboard_if.slave (DE/AGEX/WB inputs, issue/stall/
//             flush/busy_mask/sticky errors/dbg_state outputs)
// -----------------------------------------------------------------------------
module de_issue_scoreboard
    import de_issue_scoreboard_pkg::*;
#(
    parameter int CTRL_TIMEOUT_P = CTRL_TIMEOUT
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    de_issue_scoreboard_if.slave  io_sb
);

    localparam int TMRBITS = $clog2(CTRL_TIMEOUT_P + 1);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [TMRBITS-1:0]   r_timer;
    logic [TMRBITS-1:0]   w_timer_nxt;
    logic                 w_timeout_hit;

    logic                 r_ld_vld;
    logic [REGNOBITS-1:0] r_ld_reg;

    logic                 r_err_ovf;
    logic                 r_err_unf;
    logic                 r_err_to;

    logic                 w_ctrl_stall;
    logic                 w_dep_stall;
    logic                 w_issue;

    logic [REGWORDS-1:0]  w_inc;
    logic [REGWORDS-1:0]  w_dec;
    logic [REGWORDS-1:0]  w_ovf;
    logic [REGWORDS-1:0]  w_unf;
    logic [REGWORDS-1:0]  w_busy;
    logic [CNTBITS-1:0]   w_cnt [REGWORDS];

    // Stall / issue decisions are purely combinational on current state.
    always_comb begin
        w_ctrl_stall = (r_state != IDLE);
        w_dep_stall  = io_sb.de_valid & r_ld_vld &
                       ((io_sb.de_read_rs & (io_sb.de_rs == r_ld_reg)) |
                        (io_sb.de_read_rt & (io_sb.de_rt == r_ld_reg)));
        w_issue      = io_sb.de_valid & ~w_dep_stall & ~w_ctrl_stall;
    end

    // Load tag follows the instruction into AGEX; only that one slot can
    // create a hazard because MEM/WB results are forwarded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ld_vld <= 1'b0;
            r_ld_reg <= '0;
        end else begin
            r_ld_vld <= w_issue & io_sb.de_is_load & io_sb.de_wr_reg;
            r_ld_reg <= io_sb.de_wregno;
        end
    end

    for (genvar g = 0; g < REGWORDS; g++) begin : g_sb
        assign w_inc[g]  = w_issue & io_sb.de_wr_reg &
                           (io_sb.de_wregno == REGNOBITS'(g));
        assign w_dec[g]  = io_sb.wb_wr_reg & (io_sb.wb_wregno == REGNOBITS'(g));
        assign w_busy[g] = |w_cnt[g];

        sb_counter #(.W(CNTBITS)) u_cnt (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_inc   (w_inc[g]),
            .i_dec   (w_dec[g]),
            .o_cnt   (w_cnt[g]),
            .o_ovf   (w_ovf[g]),
            .o_unf   (w_unf[g])
        );
    end

    // Resolve FSM, next-state half. The timer counts cycles spent in
    // CTRL_WAIT; the watchdog fires on the cycle the timer reaches the limit.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_timeout_hit = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_issue && io_sb.de_is_ctrl) begin
                    w_state_nxt = CTRL_WAIT;
                    w_timer_nxt = '0;
                end
            end
            CTRL_WAIT: begin
                if (io_sb.agex_br_resolved) begin
                    w_state_nxt = io_sb.agex_br_mispred ? FLUSH : IDLE;
                end else if (r_timer == TMRBITS'(CTRL_TIMEOUT_P)) begin
                    w_state_nxt   = IDLE;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            FLUSH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
            r_err_to  <= 1'b0;
        end else begin
            r_err_ovf <= r_err_ovf | (|w_ovf);
            r_err_unf <= r_err_unf | (|w_unf);
            r_err_to  <= r_err_to  | w_timeout_hit;
        end
    end

    assign io_sb.issue         = w_issue;
    assign io_sb.dep_stall     = w_dep_stall;
    assign io_sb.ctrl_stall    = w_ctrl_stall;
    assign io_sb.flush         = (r_state == FLUSH);
    assign io_sb.busy_mask     = w_busy;
    assign io_sb.err_overflow  = r_err_ovf;
    assign io_sb.err_underflow = r_err_unf;
    assign io_sb.err_timeout   = r_err_to;
    assign io_sb.dbg_state     = r_state;

endmodule

// File: tb/tb_de_issue_scoreboard.sv
module tb_de_issue_scoreboard;
  import de_issue_scoreboard_pkg::*;

  typedef struct {
    bit         v;
    bit         rrs;
    bit         rrt;
    logic [3:0] rs;
    logic [3:0] rt;
    bit         wr;
    logic [3:0] wreg;
    bit         ld;
    bit         ctrl;
    bit         res;
    bit         mis;
    bit         wbw;
    logic [3:0] wbr;
  } stim_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  // reference model: pending counts, load-in-AGEX tag, control mode
  int m_cnt [16];
  bit m_ld_v;
  int m_ld_r;
  int m_mode;     // 0 = free, 1 = waiting for resolve, 2 = flushing
  int m_waited;   // cycles already spent waiting without a resolve
  bit m_ovf, m_unf, m_to;

  de_issue_scoreboard_if sb_if ();

  de_issue_scoreboard dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_sb   (sb_if)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    sb_if.de_valid         = s.v;
    sb_if.de_read_rs       = s.rrs;
    sb_if.de_read_rt       = s.rrt;
    sb_if.de_rs            = s.rs;
    sb_if.de_rt            = s.rt;
    sb_if.de_wr_reg        = s.wr;
    sb_if.de_wregno        = s.wreg;
    sb_if.de_is_load       = s.ld;
    sb_if.de_is_ctrl       = s.ctrl;
    sb_if.agex_br_resolved = s.res;
    sb_if.agex_br_mispred  = s.mis;
    sb_if.wb_wr_reg        = s.wbw;
    sb_if.wb_wregno        = s.wbr;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 16; r++) m_cnt[r] = 0;
    m_ld_v = 0; m_ld_r = 0; m_mode = 0; m_waited = 0;
    m_ovf = 0; m_unf = 0; m_to = 0;
  endtask

  // one clock cycle: drive at negedge, compare just after, advance the model
  task automatic cycle(input stim_t s);
    bit          e_dep, e_issue, e_ctrl, e_flush;
    logic [15:0] e_busy;
    bit          inc, dec;
    @(negedge clk);
    apply(s);
    #1;
    e_ctrl  = (m_mode != 0);
    e_flush = (m_mode == 2);
    e_dep   = s.v && m_ld_v && ((s.rrs && int'(s.rs) == m_ld_r) || (s.rrt && int'(s.rt) == m_ld_r));
    e_issue = s.v && !e_dep && !e_ctrl;
    for (int r = 0; r < 16; r++) e_busy[r] = (m_cnt[r] > 0);
    check("issue",      32'(sb_if.issue),         32'(e_issue));
    check("dep_stall",  32'(sb_if.dep_stall),     32'(e_dep));
    check("ctrl_stall", 32'(sb_if.ctrl_stall),    32'(e_ctrl));
    check("flush",      32'(sb_if.flush),         32'(e_flush));
    check("busy_mask",  32'(sb_if.busy_mask),     32'(e_busy));
    check("err_ovf",    32'(sb_if.err_overflow),  32'(m_ovf));
    check("err_unf",    32'(sb_if.err_underflow), 32'(m_unf));
    check("err_to",     32'(sb_if.err_timeout),   32'(m_to));
    check("state",      32'(sb_if.dbg_state),     32'(m_mode));
    // advance model to the state after the coming edge
    for (int r = 0; r < 16; r++) begin
      inc = e_issue && s.wr && int'(s.wreg) == r;
      dec = s.wbw && int'(s.wbr) == r;
      if (inc && !dec) begin
        if (m_cnt[r] == 3) m_ovf = 1; else m_cnt[r]++;
      end else if (dec && !inc) begin
        if (m_cnt[r] == 0) m_unf = 1; else m_cnt[r]--;
      end
    end
    m_ld_v = e_issue && s.ld && s.wr;
    m_ld_r = int'(s.wreg);
    if (m_mode == 2) begin
      m_mode = 0;
    end else if (m_mode == 1) begin
      if (s.res) m_mode = s.mis ? 2 : 0;
      else if (m_waited == CTRL_TIMEOUT) begin m_mode = 0; m_to = 1; end
      else m_waited++;
    end else if (e_issue && s.ctrl) begin
      m_mode = 1;
      m_waited = 0;
    end
  endtask

  // async reset asserted between edges; outputs must drop immediately
  task automatic do_reset(input string tag);
    @(negedge clk);
    apply(nop());
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_issue"}, 32'(sb_if.issue),         32'd0);
    check({tag, "_ctrl"},  32'(sb_if.ctrl_stall),    32'd0);
    check({tag, "_flush"}, 32'(sb_if.flush),         32'd0);
    check({tag, "_busy"},  32'(sb_if.busy_mask),     32'd0);
    check({tag, "_errs"},  32'({sb_if.err_overflow, sb_if.err_underflow, sb_if.err_timeout}), 32'd0);
    check({tag, "_state"}, 32'(sb_if.dbg_state),     32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  stim_t s;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    apply(nop());
    model_reset();
    #1;
    do_reset("rst0");

    // load-use: LW r3, then read r3 (one bubble), then issue
    s = nop(); s.v = 1; s.wr = 1; s.wreg = 4'd3; s.ld = 1; cycle(s);
    s = nop(); s.v = 1; s.rrs = 1; s.rs = 4'd3; s.wr = 1; s.wreg = 4'd5; cycle(s);
    cycle(s);
    // load with rt dependency
    s = nop(); s.v = 1; s.wr = 1; s.wreg = 4'd6; s.ld = 1; cycle(s);
    s = nop(); s.v = 1; s.rrt = 1; s.rt = 4'd6; cycle(s);
    cycle(s);

    // non-load RAW: ADD r4 then read r4, then retire r4
    s = nop(); s.v = 1; s.wr = 1; s.wreg = 4'd4; cycle(s);
    s = nop(); s.v = 1; s.rrs = 1; s.rs = 4'd4; cycle(s);
    s = nop(); s.wbw = 1; s.wbr = 4'd4; cycle(s);
    cycle(nop());

    // branch mispredict after 2 cycles, then branch resolved correctly
    s = nop(); s.v = 1; s.ctrl = 1; cycle(s);
    s = nop(); s.v = 1; cycle(s);
    s.res = 1; s.mis = 1; cycle(s);
    s = nop(); s.v = 1; cycle(s);
    cycle(s);
    s = nop(); s.v = 1; s.ctrl = 1; cycle(s);
    s = nop(); s.v = 1; s.res = 1; cycle(s);
    s = nop(); s.v = 1; cycle(s);
    // resolve outside CTRL_WAIT is ignored
    s = nop(); s.res = 1; s.mis = 1; cycle(s);
    cycle(nop());

    // counter edges: 4 writes to r7, issue+retire r2 together, retire r9 at 0
    s = nop(); s.v = 1; s.wr = 1; s.wreg = 4'd7;
    repeat (4) cycle(s);
    s = nop(); s.v = 1; s.wr = 1; s.wreg = 4'd2; s.wbw = 1; s.wbr = 4'd2; cycle(s);
    s = nop(); s.wbw = 1; s.wbr = 4'd9; cycle(s);
    cycle(nop());

    // watchdog: JAL with no resolve, DE keeps presenting work
    do_reset("rst1");
    s = nop(); s.v = 1; s.ctrl = 1; s.wr = 1; s.wreg = 4'd15; cycle(s);
    s = nop(); s.v = 1;
    repeat (17) cycle(s);
    cycle(s);

    // async reset mid-CTRL_WAIT with busy registers, no flush afterwards
    s = nop(); s.v = 1; s.wr = 1; s.wreg = 4'd1; cycle(s);
    s = nop(); s.v = 1; s.ctrl = 1; s.wr = 1; s.wreg = 4'd8; cycle(s);
    s = nop(); s.v = 1; repeat (2) cycle(s);
    do_reset("rst2");
    repeat (3) cycle(nop());

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      s = nop();
      s.v    = ($urandom_range(0, 3) != 0);
      s.rrs  = $urandom_range(0, 1);
      s.rrt  = $urandom_range(0, 1);
      s.rs   = 4'($urandom_range(0, 7));
      s.rt   = 4'($urandom_range(0, 7));
      s.wr   = $urandom_range(0, 1);
      s.wreg = 4'($urandom_range(0, 7));
      s.ld   = ($urandom_range(0, 2) == 0);
      s.ctrl = ($urandom_range(0, 7) == 0);
      s.res  = ($urandom_range(0, 3) == 0);
      s.mis  = $urandom_range(0, 1);
      s.wbr  = 4'($urandom_range(0, 15));
      s.wbw  = (m_cnt[s.wbr] > 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 31) == 0);
      cycle(s);
      if (i == 400) do_reset("rst3");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
